// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative 24-bit divider.
package alu_div_pkg;

  localparam int DIV_W     = 24;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 24'hFFFFFF;
  localparam logic [DIV_W-1:0] DIV_MIN_NEG   = 24'h800000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_e;

  // Magnitude of a value that is two's complement when is_signed is set.
  // The most negative value maps onto itself, which reads correctly as an
  // unsigned magnitude.
  function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v,
                                               input logic             is_signed);
    return (is_signed && v[DIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/alu_div24_if.sv
// Operand/result bundle between the execute stage and the divider.
interface alu_div24_if;
  import alu_div_pkg::*;

  logic             start;
  logic             sign;
  logic [DIV_W-1:0] A;
  logic [DIV_W-1:0] B;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] Quot;
  logic [DIV_W-1:0] Rem;
  logic             DivZero;
  logic             OFL;

  modport master (
    output start, sign, A, B,
    input  busy, done, Quot, Rem, DivZero, OFL
  );

  modport slave (
    input  start, sign, A, B,
    output busy, done, Quot, Rem, DivZero, OFL
  );

endinterface

// File: rtl/div_step24.sv
// One restoring shift-and-subtract iteration of the 24-bit divider.
module div_step24
  import alu_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic             dvd_msb,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W-1:0] rem_next,
  output logic             q_bit
);

  logic [DIV_W:0] shifted;

  // Shift the next dividend bit in, keep the difference when it fits.
  always_comb begin
    shifted  = {rem, dvd_msb};
    q_bit    = (shifted >= {1'b0, dvs});
    // The difference is always below the divisor, so it fits in DIV_W bits.
    rem_next = q_bit ? (shifted[DIV_W-1:0] - dvs) : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/alu_div24.sv
// Iterative 24-bit signed/unsigned divider with start/done handshake.
// Optional build macro ALU_DIV_EARLY_OUT_EN: when |A| < |B| the loop is
// skipped and the result is produced two cycles after start.
module alu_div24
  import alu_div_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst,
  alu_div24_if.slave  bus
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic                 load_run, load_early, load_zero, step_en, commit;
  logic [WIDTH-1:0]     a_mag, b_mag;

  logic [WIDTH-1:0]     rem_q, dvd_q, dvs_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 q_neg_q, r_neg_q, ofl_q;

  logic [WIDTH-1:0]     quot_out_q, rem_out_q;
  logic                 div_zero_q, ofl_out_q;

  logic [WIDTH-1:0]     rem_nxt;
  logic                 q_bit;

  assign a_mag = div_mag(bus.A, bus.sign);
  assign b_mag = div_mag(bus.B, bus.sign);

  div_step24 u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .dvs      (dvs_q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    load_run   = 1'b0;
    load_early = 1'b0;
    load_zero  = 1'b0;
    step_en    = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.B == '0) begin
            load_zero = 1'b1;
            state_d   = DONE;
          end else begin
`ifdef ALU_DIV_EARLY_OUT_EN
            if (a_mag < b_mag) begin
              load_early = 1'b1;
              state_d    = FIX;
            end else begin
              load_run = 1'b1;
              state_d  = RUN;
            end
`else
            load_run = 1'b1;
            state_d  = RUN;
`endif
          end
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        commit  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and one quotient bit per RUN cycle.
  always_ff @(posedge clk) begin
    // NOTE: the working registers are reset too; the cost is small and it
    // keeps the datapath free of X after reset in simulation.
    if (rst) begin
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ofl_q   <= 1'b0;
    end else if (load_run || load_early) begin
      rem_q   <= load_early ? a_mag : '0;
      dvd_q   <= load_early ? '0 : a_mag;
      dvs_q   <= b_mag;
      cnt_q   <= '0;
      q_neg_q <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      r_neg_q <= bus.sign & bus.A[WIDTH-1];
      ofl_q   <= bus.sign & (bus.A == DIV_MIN_NEG) & (bus.B == '1);
    end else if (step_en) begin
      rem_q <= rem_nxt;
      dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Result registers, updated only when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_out_q <= '0;
      rem_out_q  <= '0;
      div_zero_q <= 1'b0;
      ofl_out_q  <= 1'b0;
    end else if (load_zero) begin
      quot_out_q <= DIV_ZERO_QUOT;
      rem_out_q  <= bus.A;
      div_zero_q <= 1'b1;
      ofl_out_q  <= 1'b0;
    end else if (commit) begin
      quot_out_q <= ofl_q ? DIV_MIN_NEG : (q_neg_q ? -dvd_q : dvd_q);
      rem_out_q  <= ofl_q ? '0 : (r_neg_q ? -rem_q : rem_q);
      div_zero_q <= 1'b0;
      ofl_out_q  <= ofl_q;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.Quot    = quot_out_q;
  assign bus.Rem     = rem_out_q;
  assign bus.DivZero = div_zero_q;
  assign bus.OFL     = ofl_out_q;

endmodule

// File: tb/tb_alu_div24.sv
// Directed-vector bench for alu_div24: result values, latency, busy length,
// start-while-busy, start-in-done and mid-operation reset.
module tb_alu_div24;

  typedef struct packed {
    logic        sign;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] q;
    logic [23:0] r;
    logic        dz;
    logic        ofl;
    logic        short_op;   // |A| < |B| with nonzero B
  } vec_t;

  localparam int NVEC = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [23:0] last_q = '0;

  alu_div24_if bus ();

  alu_div24 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic int exp_lat(input vec_t v);
    if (v.b == 24'd0) return 1;
`ifdef ALU_DIV_EARLY_OUT_EN
    if (v.short_op) return 2;
`endif
    return 26;
  endfunction

  // Launch one divide; optionally pulse start again at cycle 'inject'
  // (counted from the start edge) with unrelated operands.
  task automatic run_op(input string tag, input vec_t v, input int inject);
    int  lat;
    int  busy_n;
    bit  seen;
    int  elat;
    elat   = exp_lat(v);
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = v.sign;
    bus.A     = v.a;
    bus.B     = v.b;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      bus.start = (c == inject);
      if (c == inject) begin
        bus.sign = 1'b0;
        bus.A    = 24'd50;
        bus.B    = 24'd3;
      end
      if (bus.busy) busy_n++;
      if (c == 5 && elat > 5) check({tag, " held_quot"}, bus.Quot, last_q);
      if (bus.done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({tag, " done_seen"}, seen, 1'b1);
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, busy_n, elat);
    check({tag, " quot"}, bus.Quot, v.q);
    check({tag, " rem"}, bus.Rem, v.r);
    check({tag, " divzero"}, bus.DivZero, v.dz);
    check({tag, " ofl"}, bus.OFL, v.ofl);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " done_pulse"}, bus.done, 1'b0);
    check({tag, " idle_after"}, bus.busy, 1'b0);
    last_q = v.q;
  endtask

  vec_t vecs [NVEC];
  vec_t base;

  initial begin
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    //             sign  A           B           Quot        Rem         dz    ofl   short
    vecs[0]  = '{1'b0, 24'd100,    24'd7,      24'd14,     24'd2,      1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 24'hFFFF9C, 24'd7,      24'hFFFFF2, 24'hFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 24'hFFFF9C, 24'd7,      24'h24923A, 24'h000006, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 24'h123456, 24'd0,      24'hFFFFFF, 24'h123456, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 24'h800000, 24'hFFFFFF, 24'h800000, 24'h000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 24'h800000, 24'hFFFFFF, 24'h000000, 24'h800000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 24'd5,      24'd9,      24'd0,      24'd5,      1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 24'hFFFFF9, 24'd2,      24'hFFFFFD, 24'hFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 24'd7,      24'hFFFFFE, 24'hFFFFFD, 24'd1,      1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 24'hFFFFFF, 24'd1,      24'hFFFFFF, 24'd0,      1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 24'hFFFFFF, 24'd0,      24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 24'hFFFFFB, 24'd9,      24'd0,      24'hFFFFFB, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 24'd0,      24'd5,      24'd0,      24'd0,      1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 24'h7FFFFF, 24'h800000, 24'd0,      24'h7FFFFF, 1'b0, 1'b0, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst quot", bus.Quot, 24'd0);
    check("rst rem", bus.Rem, 24'd0);
    check("rst divzero", bus.DivZero, 1'b0);
    check("rst ofl", bus.OFL, 1'b0);

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i], 0);

    // start pulsed mid-run is dropped; the first result is unaffected.
    base = vecs[0];
    run_op("start_busy", base, 10);

    // start asserted only in the done cycle is ignored.
    base = vecs[2];
    run_op("start_done", base, exp_lat(base));

    // Reset mid-operation aborts immediately.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.A     = 24'd100;
    bus.B     = 24'd7;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 12) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", bus.busy, 1'b0);
    check("midrst done", bus.done, 1'b0);
    check("midrst quot", bus.Quot, 24'd0);
    check("midrst rem", bus.Rem, 24'd0);
    check("midrst divzero", bus.DivZero, 1'b0);
    begin
      int done_n;
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.done || bus.busy) done_n++;
      end
      check("midrst no_done", done_n, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
